// File: rtl/pe_accum_stream.sv
// pe_accum_stream: signed multiply-accumulate processing element.
// Accepts (inp, wgt) pairs and multiplies them in stage 1. Stage 2 sums LEN
// products into one dot product. Each result goes into a 2-entry output FIFO.
// A credit counter throttles only the last pair of a vector, so a result is
// never produced without a FIFO slot reserved for it.
module pe_accum_stream #(
  parameter int INP_WIDTH = 8,
  parameter int WGT_WIDTH = 8,
  parameter int ACC_WIDTH = 32,
  parameter int LEN       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [INP_WIDTH-1:0] in_inp,
  input  logic [WGT_WIDTH-1:0] in_wgt,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_data
);

  localparam int PW = INP_WIDTH + WGT_WIDTH;
  localparam int CW = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(LEN - 1);

  logic [CW-1:0]               elem_cnt;
  logic [1:0]                  rsv;
  logic                        accept;
  logic                        pop;
  logic                        is_first;
  logic                        is_last;
  logic signed [PW-1:0]        inp_ext;
  logic signed [PW-1:0]        wgt_ext;
  logic signed [PW-1:0]        mult;
  logic signed [ACC_WIDTH-1:0] prod_ext;

  logic                        s1_valid;
  logic                        s1_first;
  logic                        s1_last;
  logic [ACC_WIDTH-1:0]        prod;
  logic [ACC_WIDTH-1:0]        acc;
  logic [ACC_WIDTH-1:0]        sum;
  logic                        s2_push;

  logic [ACC_WIDTH-1:0]        mem [2];
  logic                        wr_ptr;
  logic                        rd_ptr;
  logic [1:0]                  count;

  assign is_first  = (elem_cnt == '0);
  assign is_last   = (elem_cnt == LAST_IDX);
  assign in_ready  = !clr && !(is_last && (rsv == 2'd2));
  assign accept    = in_valid && in_ready;
  assign out_valid = (count != 2'd0);
  assign pop       = out_valid && out_ready;
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  // Sign-extend both operands to the full product width.
  // The PW-bit product is then exact and can be widened to the accumulator.
  assign inp_ext  = {{WGT_WIDTH{in_inp[INP_WIDTH-1]}}, in_inp};
  assign wgt_ext  = {{INP_WIDTH{in_wgt[WGT_WIDTH-1]}}, in_wgt};
  assign mult     = inp_ext * wgt_ext;
  assign prod_ext = ACC_WIDTH'(mult);
  assign sum      = s1_first ? prod : acc + prod;

  // Position within the current vector; clr abandons the partial vector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      elem_cnt <= '0;
    end else if (clr) begin
      elem_cnt <= '0;
    end else if (accept) begin
      elem_cnt <= is_last ? '0 : elem_cnt + 1'b1;
    end
  end

  // Credits: queued results plus results still in the pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsv <= 2'd0;
    end else begin
      case ({accept && is_last, pop})
        2'b10:   rsv <= rsv + 2'd1;
        2'b01:   rsv <= rsv - 2'd1;
        default: rsv <= rsv;
      endcase
    end
  end

  // Stage 1: register the product together with its vector-position tags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      prod     <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_first <= is_first;
        s1_last  <= is_last;
        prod     <= prod_ext;
      end
    end
  end

  // Stage 2: accumulate, restarting on a first product.
  // Flag that acc holds a finished dot product.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      s2_push <= 1'b0;
    end else begin
      s2_push <= s1_valid && s1_last;
      if (s1_valid) begin
        acc <= sum;
      end
    end
  end

  // Two-entry in-order result FIFO; the credit counter guarantees no overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (s2_push) begin
        mem[wr_ptr] <= acc;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({s2_push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule
